// File: rtl/mtimer_mch_if.sv
// Register bus and interrupt lines of the multi-channel machine timer.
// Writes are taken every cycle that we_i is high (no backpressure); reads are combinational from addr_i.
interface mtimer_mch_if;
    logic        we_i;
    logic [7:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        irq_o;
    logic [2:0]  irq_id_o;

    modport master (output we_i, addr_i, wdata_i, input rdata_o, irq_o, irq_id_o);
    modport slave  (input we_i, addr_i, wdata_i, output rdata_o, irq_o, irq_id_o);
endinterface

// File: rtl/mtimer_mch.sv
// 64-bit machine timer with CH_NUM compare channels (one-shot or periodic) and a registered interrupt.
// Optional prescaler is built only when MTIMER_PRESC_EN is defined.
module mtimer_mch #(
    parameter int CH_NUM  = 4,
    parameter int PRESC_W = 8
) (
    input logic        clk,
    input logic        rst_n,
    mtimer_mch_if.slave bus
);
    logic              en;
    logic [63:0]       mtime;
    logic [CH_NUM-1:0] pend, mask, armed, periodic, match, act;
    logic [63:0]       cmp    [CH_NUM];
    logic [31:0]       period [CH_NUM];
    logic              tick, irq;
    logic [2:0]        irq_id, irq_id_nxt;

    logic wr_ctrl, wr_mtl, wr_mth, wr_pend, wr_mask, clr;
    logic [CH_NUM-1:0] wr_cmp_lo, wr_cmp_hi, wr_period, wr_mode;

    always_comb begin
        wr_ctrl = bus.we_i && (bus.addr_i == 8'h00);
        wr_mtl  = bus.we_i && (bus.addr_i == 8'h02);
        wr_mth  = bus.we_i && (bus.addr_i == 8'h03);
        wr_pend = bus.we_i && (bus.addr_i == 8'h04);
        wr_mask = bus.we_i && (bus.addr_i == 8'h05);
        clr     = wr_ctrl && bus.wdata_i[1];
        for (int k = 0; k < CH_NUM; k++) begin
            wr_cmp_lo[k] = bus.we_i && (bus.addr_i == 8'(16 + 2 * k));
            wr_cmp_hi[k] = bus.we_i && (bus.addr_i == 8'(17 + 2 * k));
            wr_period[k] = bus.we_i && (bus.addr_i == 8'(48 + k));
            wr_mode[k]   = bus.we_i && (bus.addr_i == 8'(56 + k));
            match[k]     = armed[k] && (mtime >= cmp[k]);
        end
    end

`ifdef MTIMER_PRESC_EN
    logic [PRESC_W-1:0] presc, presc_cnt;
    logic               wr_presc;

    assign wr_presc = bus.we_i && (bus.addr_i == 8'h01);
    assign tick     = en && (presc_cnt == presc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            presc_cnt <= '0;
        end else if (wr_presc) begin
            presc     <= bus.wdata_i[PRESC_W-1:0];
            presc_cnt <= '0;
        end else if (en) begin
            presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
        end
    end
`else
    assign tick = en;
`endif

    // Software writes to mtime (or CLR) override the increment in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en    <= 1'b0;
            mtime <= '0;
            mask  <= '0;
        end else begin
            if (wr_ctrl) en <= bus.wdata_i[0];
            if (wr_mask) mask <= bus.wdata_i[CH_NUM-1:0];
            if (clr)         mtime        <= '0;
            else if (wr_mtl) mtime[31:0]  <= bus.wdata_i;
            else if (wr_mth) mtime[63:32] <= bus.wdata_i;
            else if (tick)   mtime        <= mtime + 64'd1;
        end
    end

    // A hardware match sets PEND even if the same bit is being cleared by software.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            armed    <= '0;
            periodic <= '0;
            for (int k = 0; k < CH_NUM; k++) begin
                cmp[k]    <= '1;
                period[k] <= '0;
            end
        end else begin
            pend <= (pend & ~(wr_pend ? bus.wdata_i[CH_NUM-1:0] : '0)) | match;
            for (int k = 0; k < CH_NUM; k++) begin
                if (wr_period[k]) period[k]   <= bus.wdata_i;
                if (wr_mode[k])   periodic[k] <= bus.wdata_i[0];
                if (wr_cmp_hi[k]) begin
                    cmp[k][63:32] <= bus.wdata_i;
                    armed[k]      <= 1'b1;
                end else begin
                    if (wr_cmp_lo[k]) begin
                        cmp[k][31:0] <= bus.wdata_i;
                    end else if (match[k] && periodic[k] && (period[k] != 32'd0)) begin
                        cmp[k] <= cmp[k] + {32'd0, period[k]};
                    end
                    if (match[k] && !(periodic[k] && (period[k] != 32'd0))) armed[k] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        act        = pend & mask;
        irq_id_nxt = '0;
        for (int k = CH_NUM - 1; k >= 0; k--) begin
            if (act[k]) irq_id_nxt = 3'(k);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq    <= 1'b0;
            irq_id <= '0;
        end else begin
            irq    <= |act;
            irq_id <= irq_id_nxt;
        end
    end

    assign bus.irq_o    = irq;
    assign bus.irq_id_o = irq_id;

    always_comb begin
        bus.rdata_o = '0;
        case (bus.addr_i)
            8'h00:   bus.rdata_o = {31'd0, en};
`ifdef MTIMER_PRESC_EN
            8'h01:   bus.rdata_o = 32'(presc);
`else
            8'h01:   bus.rdata_o = 32'({PRESC_W{1'b0}});
`endif
            8'h02:   bus.rdata_o = mtime[31:0];
            8'h03:   bus.rdata_o = mtime[63:32];
            8'h04:   bus.rdata_o = 32'(pend);
            8'h05:   bus.rdata_o = 32'(mask);
            default: bus.rdata_o = '0;
        endcase
        for (int k = 0; k < CH_NUM; k++) begin
            if (bus.addr_i == 8'(16 + 2 * k)) bus.rdata_o = cmp[k][31:0];
            if (bus.addr_i == 8'(17 + 2 * k)) bus.rdata_o = cmp[k][63:32];
            if (bus.addr_i == 8'(48 + k))     bus.rdata_o = period[k];
            if (bus.addr_i == 8'(56 + k))     bus.rdata_o = {30'd0, armed[k], periodic[k]};
        end
    end
endmodule

// File: tb/tb_mtimer_mch.sv
// Directed bench for mtimer_mch: register reads and interrupt edges are checked by a monitor
// against expected queues filled by the stimulus.
module tb_mtimer_mch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rd_strobe = 1'b0;
    logic irq_prev = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];
    logic [2:0]  irq_exp_q[$];

`ifdef MTIMER_PRESC_EN
    localparam logic [31:0] PRESC_EXP = 32'd3;
    localparam logic [31:0] MT40_EXP  = 32'd10;
`else
    localparam logic [31:0] PRESC_EXP = 32'd0;
    localparam logic [31:0] MT40_EXP  = 32'd40;
`endif

    mtimer_mch_if bus();

    mtimer_mch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- driver tasks (each starts and ends 1ns after a rising edge)
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus.we_i = 1'b1;
        bus.addr_i = a;
        bus.wdata_i = d;
        @(posedge clk);
        #1;
        bus.we_i = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e, input string nm);
        bus.addr_i = a;
        rd_exp_q.push_back(e);
        rd_name_q.push_back(nm);
        rd_strobe = 1'b1;
        @(posedge clk);
        #1;
        rd_strobe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run(input int incs);
        wr(8'h00, 32'd1);
        if (incs > 1) idle(incs - 1);
        wr(8'h00, 32'd0);
    endtask

    task automatic chk(input logic [31:0] got, input logic [31:0] e, input string nm);
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, e);
        end
    endtask

    // ---------------- monitor / scoreboard
    always @(negedge clk) begin
        logic [31:0] e;
        string nm;
        if (rd_strobe) begin
            total++;
            if (rd_exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_queue: read with no expected value, got %h", bus.rdata_o);
            end else begin
                e = rd_exp_q.pop_front();
                nm = rd_name_q.pop_front();
                if (bus.rdata_o !== e) begin
                    bad++;
                    $display("FAIL %s: got %h expected %h", nm, bus.rdata_o, e);
                end
            end
        end
        if (bus.irq_o === 1'b1 && irq_prev !== 1'b1) begin
            total++;
            if (irq_exp_q.size() == 0) begin
                bad++;
                $display("FAIL irq_unexpected: irq_id %0d with nothing expected", bus.irq_id_o);
            end else begin
                e = 32'(irq_exp_q.pop_front());
                if (32'(bus.irq_id_o) !== e) begin
                    bad++;
                    $display("FAIL irq_id: got %0d expected %0d", bus.irq_id_o, e);
                end
            end
        end
        irq_prev <= bus.irq_o;
    end

    // ---------------- stimulus
    initial begin
        bus.we_i = 1'b0;
        bus.addr_i = '0;
        bus.wdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset state
        chk(32'(bus.irq_o), 32'd0, "irq_rst");
        rd(8'h00, 32'd0, "ctrl_rst");
        rd(8'h02, 32'd0, "mtime_lo_rst");
        rd(8'h03, 32'd0, "mtime_hi_rst");
        rd(8'h04, 32'd0, "pend_rst");
        rd(8'h05, 32'd0, "mask_rst");
        rd(8'h10, 32'hFFFF_FFFF, "cmp0_lo_rst");
        rd(8'h17, 32'hFFFF_FFFF, "cmp3_hi_rst");
        rd(8'h30, 32'd0, "period0_rst");
        rd(8'h38, 32'd0, "mode0_rst");
        rd(8'h06, 32'd0, "unmapped");

        // prescaler: 40 enabled cycles with PRESC=3
        wr(8'h01, 32'd3);
        rd(8'h01, PRESC_EXP, "presc_rd");
        run(40);
        rd(8'h02, MT40_EXP, "presc_mtime");
        wr(8'h01, 32'd0);
        wr(8'h00, 32'd2);
        rd(8'h00, 32'd0, "ctrl_clr_reads0");
        rd(8'h02, 32'd0, "mtime_clr");

        // one-shot on channel 0 at 100
        wr(8'h02, 32'd90);
        wr(8'h10, 32'd100);
        wr(8'h11, 32'd0);
        wr(8'h05, 32'd1);
        rd(8'h38, 32'd2, "mode0_armed");
        irq_exp_q.push_back(3'd0);
        run(9);
        idle(2);
        rd(8'h04, 32'd0, "pend_at_99");
        rd(8'h02, 32'd99, "mtime_99");
        run(1);
        idle(2);
        rd(8'h04, 32'd1, "pend_oneshot");
        rd(8'h38, 32'd0, "mode0_disarmed");
        rd(8'h10, 32'd100, "cmp0_kept");
        wr(8'h04, 32'd1);
        rd(8'h04, 32'd0, "pend_w1c");
        run(6);
        idle(2);
        rd(8'h04, 32'd0, "no_refire");

        // periodic channel 1: 50, 70, 90
        wr(8'h05, 32'd2);
        wr(8'h02, 32'd40);
        wr(8'h31, 32'd20);
        wr(8'h39, 32'd1);
        wr(8'h12, 32'd50);
        repeat (3) irq_exp_q.push_back(3'd1);
        wr(8'h13, 32'd0);
        rd(8'h39, 32'd3, "mode1_armed");
        run(11);
        idle(2);
        rd(8'h04, 32'd2, "pend1_at50");
        rd(8'h12, 32'd70, "cmp1_70");
        wr(8'h04, 32'd2);
        rd(8'h04, 32'd0, "pend1_clr1");
        run(20);
        idle(2);
        rd(8'h04, 32'd2, "pend1_at70");
        rd(8'h12, 32'd90, "cmp1_90");
        wr(8'h04, 32'd2);
        rd(8'h04, 32'd0, "pend1_clr2");
        run(20);
        idle(2);
        rd(8'h04, 32'd2, "pend1_at90");
        rd(8'h12, 32'd110, "cmp1_110");
        rd(8'h13, 32'd0, "cmp1_hi");
        wr(8'h04, 32'd2);

        // priority: channels 2 and 3 both at 200, channel 0 pending but masked
        wr(8'h12, 32'hFFFF_FFFF);
        wr(8'h13, 32'hFFFF_FFFF);
        wr(8'h10, 32'd150);
        wr(8'h11, 32'd0);
        wr(8'h05, 32'hC);
        wr(8'h14, 32'd200);
        wr(8'h15, 32'd0);
        wr(8'h16, 32'd200);
        wr(8'h17, 32'd0);
        irq_exp_q.push_back(3'd2);
        wr(8'h02, 32'd195);
        run(5);
        idle(2);
        rd(8'h04, 32'hD, "pend_collide");
        rd(8'h3A, 32'd0, "mode2_oneshot");
        rd(8'h02, 32'd200, "mtime_200");
        wr(8'h04, 32'hD);
        rd(8'h04, 32'd0, "pend_clr_all");

        // W1C racing a hardware set: channel 2 re-matches every cycle
        wr(8'h32, 32'd1);
        wr(8'h3A, 32'd1);
        wr(8'h14, 32'd100);
        irq_exp_q.push_back(3'd2);
        wr(8'h15, 32'd0);
        wr(8'h04, 32'd4);
        rd(8'h04, 32'd4, "pend2_set_wins");
        idle(120);
        rd(8'h14, 32'd201, "cmp2_final");
        wr(8'h04, 32'd4);
        rd(8'h04, 32'd0, "pend2_clr");

        // wrap through 2^64
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr(8'h03, 32'hFFFF_FFFF);
        wr(8'h02, 32'hFFFF_FFFE);
        rd(8'h02, 32'hFFFF_FFFE, "mtime_pre_wrap");
        run(2);
        rd(8'h02, 32'd0, "wrap_lo");
        rd(8'h03, 32'd0, "wrap_hi");
        wr(8'h10, 32'd1);
        wr(8'h11, 32'd0);
        wr(8'h05, 32'd1);
        rd(8'h04, 32'd0, "pend_before_cmp1");
        irq_exp_q.push_back(3'd0);
        run(1);
        idle(2);
        rd(8'h04, 32'd1, "pend_after_wrap");

        // asynchronous reset while irq is high
        chk(32'(bus.irq_o), 32'd1, "irq_before_rst");
        rst_n = 1'b0;
        #1;
        chk(32'(bus.irq_o), 32'd0, "irq_async_rst");
        chk(32'(bus.irq_id_o), 32'd0, "irq_id_async_rst");
        rd(8'h10, 32'hFFFF_FFFF, "cmp0_lo_in_rst");
        rd(8'h11, 32'hFFFF_FFFF, "cmp0_hi_in_rst");
        rst_n = 1'b1;
        rd(8'h04, 32'd0, "pend_after_rst");
        rd(8'h02, 32'd0, "mtime_after_rst");
        wr(8'h05, 32'hF);
        run(20);
        idle(2);
        rd(8'h04, 32'd0, "no_pend_after_rst");
        chk(32'(bus.irq_o), 32'd0, "no_irq_after_rst");

        idle(2);
        chk(32'(rd_exp_q.size() + irq_exp_q.size()), 32'd0, "scoreboard_drained");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mtimer_mch.md
MTIMER_MCH -- requirements
Module: mtimer_mch

Interface
REQ-001 SHALL have parameter CH_NUM, default 4, number of compare channels (legal range 1..8).
REQ-002 SHALL have parameter PRESC_W, default 8, prescaler width in bits (legal range 1..16).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port we_i, input, 1 bit: register write enable.
REQ-006 SHALL have port addr_i, input, 8 bits: register word address.
REQ-007 SHALL have port wdata_i, input, 32 bits: write data, captured synchronously.
REQ-008 SHALL have port rdata_o, output, 32 bits: read data, combinational from addr_i.
REQ-009 SHALL have port irq_o, output, 1 bit: registered OR of the masked pending bits.
REQ-010 SHALL have port irq_id_o, output, 3 bits: registered index of the lowest-numbered masked pending channel.

Function
REQ-011 SHALL use this register map (unmapped reads return 0; unmapped writes are ignored):
- 0x00 CTRL: [0] EN is the count enable; [1] CLR clears mtime, is self-clearing and reads 0.
- 0x01 PRESC: PRESC_W bits.
- 0x02 MTIME low word; 0x03 MTIME high word.
- 0x04 PEND, bits [CH_NUM-1:0]: write-1-to-clear.
- 0x05 MASK, bits [CH_NUM-1:0]: 1 enables the channel.
- 0x10+2k CMP[k] low word; 0x11+2k CMP[k] high word.
- 0x30+k PERIOD[k], 32 bits.
- 0x38+k MODE[k]: [0] PERIODIC; [1] ARMED, read-only.
REQ-012 SHALL keep mtime as a 64-bit counter that increments by 1 on each prescaler tick while EN=1 and wraps from 2^64-1 to 0.
REQ-013 SHALL generate a prescaler tick when the prescaler counter equals PRESC; the counter then returns to 0, so mtime advances every PRESC+1 cycles.
REQ-014 SHALL hold the prescaler counter while EN=0; a write to PRESC SHALL also reset the prescaler counter to 0.
REQ-015 SHALL give a software write to MTIME low or high, or CLR=1, priority over the increment in the same cycle; the half that is not written SHALL keep its value.
REQ-016 SHALL detect a channel match when ARMED[k]=1 and mtime >= CMP[k] (unsigned 64-bit compare); PEND[k] SHALL be set on the next edge.
REQ-017 SHALL handle a match as follows:
- PERIODIC=1 and PERIOD!=0: CMP[k] <= CMP[k] + zero-extended PERIOD[k], modulo 2^64, and ARMED stays 1.
- Otherwise: ARMED[k] is cleared, so the channel fires once.
REQ-018 SHALL set ARMED[k] on a write to CMP[k] high; a write to CMP[k] low alone SHALL not change ARMED.
REQ-019 SHALL let a hardware PEND set win over a same-cycle W1C on the same bit.
REQ-020 SHALL register irq_o and irq_id_o from PEND & MASK, so they lag PEND by one cycle; irq_id_o SHALL be 0 when no bit is set.
REQ-021 SHALL mask only the outputs with MASK; PEND SHALL still set while MASK[k]=0.
REQ-022 SHALL complete a write in one cycle, with its effect visible on rdata_o in the next cycle.

Reset
REQ-023 SHALL, on rst_n low, force the following values immediately:
- CTRL, PRESC, prescaler counter, mtime, PEND, MASK, PERIOD and MODE: 0.
- ARMED: 0.
- CMP[k]: 64'hFFFF_FFFF_FFFF_FFFF.
- irq_o and irq_id_o: 0.
REQ-024 SHALL abort any match in progress when reset is asserted mid-operation; no PEND SHALL be set after reset is released until a new match occurs.

Configuration
REQ-025 SHALL, when macro MTIMER_PRESC_EN is defined, implement the prescaler as in REQ-013/014.
REQ-026 SHALL, without MTIMER_PRESC_EN, omit the PRESC register and prescaler; PRESC SHALL read 0, writes to it SHALL be ignored, and mtime SHALL increment every cycle while EN=1.

Verification
REQ-027 SHALL run a one-shot test: PRESC=0, CMP0=100, MASK=1, EN=1 -> PEND[0] is set at mtime>=100, irq_o=1 one cycle later with irq_id_o=0, ARMED[0]=0, and no refire.
REQ-028 SHALL run a periodic test: CMP1=50, PERIOD1=20, PERIODIC=1 -> PEND[1] is set at 50, 70 and 90, with W1C between events; CMP1 reads 110 after the third match.
REQ-029 SHALL run a prescaler test: PRESC=3, EN=1 for 40 cycles -> mtime=10; without MTIMER_PRESC_EN -> mtime=40.
REQ-030 SHALL run a priority and collision test: channels 2 and 3 match in the same cycle, MASK=0xC -> irq_id_o=2; a W1C of PEND[2] in the same cycle as a new hardware set leaves PEND[2]=1.
REQ-031 SHALL run a wrap test: mtime written to 0xFFFFFFFF_FFFFFFFE, EN=1 -> mtime reaches 0 after 2 ticks; CMP0=1 then matches after 1 more tick.
REQ-032 SHALL run a reset test: rst_n is asserted while irq_o=1 -> all outputs go to 0 immediately, CMP reads all-ones, and no irq_o after release.
